lane_slot_scheduler: RTL and testbench



---
 rtl/lane_slot_scheduler_pkg.sv | 19 +
 rtl/lane_slot_scheduler_rr_arbiter4.sv | 28 ++
 rtl/lane_slot_scheduler.sv | 101 ++++++++++
 tb/tb_lane_slot_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lane_slot_scheduler_pkg.sv
// Shared definitions for the lane slot scheduler: lane count, COM byte,
// scheduler state encoding and counter width derivation.
package lane_slot_scheduler_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned LANE_W    = 2;
   localparam logic [7:0]  K28_5     = 8'hBC;

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } sched_state_e;

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lane_slot_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick: the first requester at or after ptr
// (modulo 4) wins.
module rr_arbiter4
   import lane_slot_scheduler_pkg::*;
(
   input  logic [NUM_LANES-1:0] req,
   input  logic [LANE_W-1:0]    ptr,
   output logic [NUM_LANES-1:0] gnt,
   output logic [LANE_W-1:0]    gnt_idx,
   output logic                 any
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      // Scan farthest-first so the candidate closest to ptr is written last and wins.
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (req[ptr + LANE_W'(i)]) begin
            gnt     = NUM_LANES'(1) << (ptr + LANE_W'(i));
            gnt_idx = ptr + LANE_W'(i);
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lane_slot_scheduler.sv
// Shares one byte-wide serializer among four lanes: one byte per slot of
// SLOT_CYCLES clocks, round-robin, with COM/idle bytes during sync and starvation.
module lane_slot_scheduler
   import lane_slot_scheduler_pkg::*;
#(
   parameter int unsigned SLOT_CYCLES = 8,
   parameter int unsigned SYNC_SLOTS  = 4,
   parameter logic [7:0]  IDLE_BYTE   = K28_5
) (
   input  logic                   clk16f,
   input  logic                   reset,
   input  logic [NUM_LANES-1:0]   lane_en,
   input  logic [NUM_LANES-1:0]   lane_valid,
   input  logic [8*NUM_LANES-1:0] lane_data,
   output logic [NUM_LANES-1:0]   lane_ready,
   output logic                   ser_load,
   output logic [7:0]             ser_data,
   output logic [LANE_W-1:0]      ser_lane,
   output logic                   ser_is_idle,
   output logic                   sync_done
);

   localparam int unsigned SLOT_W = cnt_width(SLOT_CYCLES);
   localparam int unsigned SYNC_W = cnt_width(SYNC_SLOTS);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_SLOTS - 1);

   sched_state_e          state, state_nxt;
   logic [SLOT_W-1:0]     slot_cnt;
   logic [SYNC_W-1:0]     sync_cnt;
   logic [LANE_W-1:0]     rr_ptr;
   logic                  decision;

   logic [NUM_LANES-1:0]  gnt;
   logic [LANE_W-1:0]     gnt_idx;
   logic                  gnt_any;

   assign decision = (slot_cnt == SLOT_LAST);

   rr_arbiter4 u_arb (
      .req     (lane_valid & lane_en),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   // State register.
   always_ff @(posedge clk16f) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= ST_SYNC;
      else       state <= state_nxt;
   end

   // Next-state logic: leave SYNC after the last forced COM slot.
   always_comb begin
      state_nxt = state;
      if (state == ST_SYNC && decision && sync_cnt == SYNC_LAST)
         state_nxt = ST_ACTIVE;
   end

   // Pop strobe: only on an ACTIVE decision cycle, so lanes are never popped during sync.
   always_comb begin
      lane_ready = '0;
      if (state == ST_ACTIVE && decision)
         lane_ready = gnt;
   end

   // Slot counter, sync counter, round-robin pointer and serializer output registers.
   always_ff @(posedge clk16f) begin
      if (reset) begin
         slot_cnt    <= '0;
         sync_cnt    <= '0;
         rr_ptr      <= '0;
         ser_load    <= 1'b0;
         ser_data    <= '0;
         ser_lane    <= '0;
         ser_is_idle <= 1'b0;
         sync_done   <= 1'b0;
      end else begin
         slot_cnt  <= decision ? '0 : slot_cnt + 1'b1;
         ser_load  <= decision;
         sync_done <= (state_nxt == ST_ACTIVE);
         if (decision) begin
            if (state == ST_ACTIVE && gnt_any) begin
               ser_data    <= lane_data[8*gnt_idx +: 8];
               ser_lane    <= gnt_idx;
               ser_is_idle <= 1'b0;
               rr_ptr      <= gnt_idx + 1'b1;
            end else begin
               ser_data    <= IDLE_BYTE;
               ser_lane    <= '0;
               ser_is_idle <= 1'b1;
            end
            if (state == ST_SYNC)
               sync_cnt <= sync_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lane_slot_scheduler.sv
// Directed bench for lane_slot_scheduler: sync phase, round-robin order,
// pointer retention, lane masking, mid-slot reset and short valid pulses.
module tb_lane_slot_scheduler;

   logic        clk16f = 1'b0;
   logic        reset  = 1'b1;
   logic [3:0]  lane_en;
   logic [3:0]  lane_valid;
   logic [31:0] lane_data;
   logic [3:0]  lane_ready;
   logic        ser_load;
   logic [7:0]  ser_data;
   logic [1:0]  ser_lane;
   logic        ser_is_idle;
   logic        sync_done;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   // Per-slot observations gathered by run_slot.
   logic [7:0] s_data;
   logic [1:0] s_lane;
   logic       s_idle;
   logic       s_load;
   logic [3:0] s_rdy_dec;
   logic [3:0] s_rdy_other;
   int         s_bad_loads;

   localparam logic [31:0] BYTES_DEFAULT = 32'h4332_2110;

   always #5 clk16f = ~clk16f;

   lane_slot_scheduler dut (
      .clk16f      (clk16f),
      .reset       (reset),
      .lane_en     (lane_en),
      .lane_valid  (lane_valid),
      .lane_data   (lane_data),
      .lane_ready  (lane_ready),
      .ser_load    (ser_load),
      .ser_data    (ser_data),
      .ser_lane    (ser_lane),
      .ser_is_idle (ser_is_idle),
      .sync_done   (sync_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at the negedge of a slot_cnt==0 cycle; returns at the negedge of
   // the next slot's slot_cnt==0 cycle, where the load from this slot is visible.
   // With pulse set, lane 1 is valid only during slot_cnt==3.
   task automatic run_slot(input logic pulse);
      s_rdy_other = '0;
      s_rdy_dec   = '0;
      s_bad_loads = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) s_rdy_dec = lane_ready;
         else        s_rdy_other |= lane_ready;
         if (i != 0 && ser_load) s_bad_loads++;
         if (pulse) lane_valid = (i == 3) ? 4'b0010 : 4'b0000;
         @(negedge clk16f);
      end
      s_load = ser_load;
      s_data = ser_data;
      s_lane = ser_lane;
      s_idle = ser_is_idle;
   endtask

   task automatic check_slot(input string tag, input logic [7:0] d, input logic [1:0] l,
                             input logic idl, input logic [3:0] rdy);
      check({tag, ".load"},      32'(s_load),      32'd1);
      check({tag, ".data"},      32'(s_data),      32'(d));
      check({tag, ".lane"},      32'(s_lane),      32'(l));
      check({tag, ".idle"},      32'(s_idle),      32'(idl));
      check({tag, ".rdy_dec"},   32'(s_rdy_dec),   32'(rdy));
      check({tag, ".rdy_other"}, 32'(s_rdy_other), 32'd0);
      check({tag, ".spacing"},   32'(s_bad_loads), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".ser_load"},   32'(ser_load),    32'd0);
      check({tag, ".ser_data"},   32'(ser_data),    32'd0);
      check({tag, ".ser_lane"},   32'(ser_lane),    32'd0);
      check({tag, ".ser_idle"},   32'(ser_is_idle), 32'd0);
      check({tag, ".sync_done"},  32'(sync_done),   32'd0);
      check({tag, ".lane_ready"}, 32'(lane_ready),  32'd0);
   endtask

   initial begin
      lane_en    = 4'b1111;
      lane_valid = 4'b1111;
      lane_data  = BYTES_DEFAULT;
      reset      = 1'b1;
      repeat (3) @(negedge clk16f);
      check_zero("reset");

      // Sync phase: four COM slots with every lane valid, then the first pop.
      reset = 1'b0;
      for (int s = 1; s <= 4; s++) begin
         run_slot(1'b0);
         check_slot($sformatf("sync%0d", s), 8'hBC, 2'd0, 1'b1, 4'b0000);
         if (s == 1) check("sync1.sync_done", 32'(sync_done), 32'd0);
      end
      check("sync4.sync_done", 32'(sync_done), 32'd1);
      run_slot(1'b0);
      check_slot("first_pop", 8'h10, 2'd0, 1'b0, 4'b0001);

      // Round-robin across all lanes: 1,2,3,0.
      run_slot(1'b0); check_slot("rr_l1", 8'h21, 2'd1, 1'b0, 4'b0010);
      run_slot(1'b0); check_slot("rr_l2", 8'h32, 2'd2, 1'b0, 4'b0100);
      run_slot(1'b0); check_slot("rr_l3", 8'h43, 2'd3, 1'b0, 4'b1000);
      run_slot(1'b0); check_slot("rr_l0", 8'h10, 2'd0, 1'b0, 4'b0001);

      // Steer rr_ptr to 3, then only lane 2 valid.
      run_slot(1'b0); check_slot("steer_l1", 8'h21, 2'd1, 1'b0, 4'b0010);
      run_slot(1'b0); check_slot("steer_l2", 8'h32, 2'd2, 1'b0, 4'b0100);
      lane_valid = 4'b0100;
      lane_data  = 32'h43A5_2110;
      run_slot(1'b0); check_slot("solo_a", 8'hA5, 2'd2, 1'b0, 4'b0100);
      run_slot(1'b0); check_slot("solo_b", 8'hA5, 2'd2, 1'b0, 4'b0100);
      lane_valid = 4'b0000;
      run_slot(1'b0); check_slot("starve", 8'hBC, 2'd0, 1'b1, 4'b0000);
      // rr_ptr must still be 3, so lane 3 wins with everyone valid.
      lane_valid = 4'b1111;
      lane_data  = BYTES_DEFAULT;
      run_slot(1'b0); check_slot("ptr_kept", 8'h43, 2'd3, 1'b0, 4'b1000);

      // Enable mask 1010: lanes 1 and 3 alternate.
      lane_en = 4'b1010;
      run_slot(1'b0); check_slot("mask_a", 8'h21, 2'd1, 1'b0, 4'b0010);
      run_slot(1'b0); check_slot("mask_b", 8'h43, 2'd3, 1'b0, 4'b1000);
      run_slot(1'b0); check_slot("mask_c", 8'h21, 2'd1, 1'b0, 4'b0010);

      // Reset at slot_cnt==5 in ACTIVE.
      lane_en = 4'b1111;
      repeat (5) @(negedge clk16f);
      reset = 1'b1;
      @(negedge clk16f);
      check_zero("mid_reset");
      reset = 1'b0;
      for (int s = 1; s <= 4; s++) begin
         run_slot(1'b0);
         check_slot($sformatf("resync%0d", s), 8'hBC, 2'd0, 1'b1, 4'b0000);
      end
      run_slot(1'b0); check_slot("repop", 8'h10, 2'd0, 1'b0, 4'b0001);

      // Lane 1 valid only mid-slot: never popped, idle slots result.
      run_slot(1'b1); check_slot("pulse_a", 8'hBC, 2'd0, 1'b1, 4'b0000);
      run_slot(1'b1); check_slot("pulse_b", 8'hBC, 2'd0, 1'b1, 4'b0000);
      lane_valid = 4'b0010;
      run_slot(1'b0); check_slot("steady_l1", 8'h21, 2'd1, 1'b0, 4'b0010);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
